trial_tracker: RTL and testbench

- Parametrised multi-player trial counter for the guessing-number game.
- Converts a debounced submit button into single-cycle guess events and counts attempts per player in round-robin turn order.
- Declares WON on a correct guess or LOST when every player has used the latched trial budget.
- Sits between the input/debounce stage and the display/game-control FSM.
- Fully synchronous to one clock.

---
 rtl/trial_pkg.sv | 17 +
 rtl/edge_pulse.sv | 22 ++
 rtl/trial_tracker.sv | 103 ++++++++++
 tb/tb_trial_tracker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trial_pkg.sv
// Shared definitions for the multi-player trial tracker: state encoding and
// the player-index width helper.
package trial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  // Player-index width; a single player still needs a 1-bit turn port.
  function automatic int pw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Turns a synchronised level into a single-cycle pulse on the selected edge
// (EDGE=0: falling, EDGE=1: rising).
module edge_pulse #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic r_q;

  // Reset to the inactive level so a button held through reset yields no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= EDGE;
    else     r_q <= level;
  end

  assign pulse = EDGE ? (~r_q & level) : (r_q & ~level);

endmodule

// File: rtl/trial_tracker.sv
// Round-robin per-player attempt counter for the guessing game; converts
// submit edges into guesses and declares WON or LOST.
module trial_tracker
  import trial_pkg::*;
#(
  parameter  int N_PLAYERS   = 2,
  parameter  int CNT_W       = 4,
  parameter  bit SUBMIT_EDGE = 1'b0,
  localparam int PW          = pw(N_PLAYERS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       submit,
  input  logic                       correct,
  input  logic [CNT_W-1:0]           trials,
  output logic [N_PLAYERS*CNT_W-1:0] count,
  output logic [PW-1:0]              turn,
  output logic [CNT_W-1:0]           remaining,
  output logic [1:0]                 state_o,
  output logic                       over,
  output logic                       win,
  output logic [PW-1:0]              winner
);

  localparam logic [PW-1:0] LAST = PW'(N_PLAYERS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count [N_PLAYERS];
  logic [CNT_W-1:0] r_trials;
  logic [PW-1:0]    r_turn;
  logic [PW-1:0]    r_winner;
  logic             r_over;
  logic             r_win;

  logic             w_ev;
  logic [CNT_W-1:0] w_next_cnt;

  edge_pulse #(.EDGE(SUBMIT_EDGE)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (submit),
    .pulse (w_ev)
  );

  assign w_next_cnt = r_count[r_turn] + CNT_W'(1);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_trials <= '0;
      r_turn   <= '0;
      r_winner <= '0;
      r_over   <= 1'b0;
      r_win    <= 1'b0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset.
      for (int p = 0; p < N_PLAYERS; p++) r_count[p] <= '0;
    end else if (start && (trials != '0)) begin
      // start outranks a coincident guess event, which is simply dropped.
      r_state  <= ST_PLAY;
      r_trials <= trials;
      r_turn   <= '0;
      r_winner <= '0;
      r_over   <= 1'b0;
      r_win    <= 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) r_count[p] <= '0;
    end else if ((r_state == ST_PLAY) && w_ev) begin
      r_count[r_turn] <= w_next_cnt;
      if (correct) begin
        r_state  <= ST_WON;
        r_winner <= r_turn;
        r_win    <= 1'b1;
        r_over   <= 1'b1;
      end else if ((r_turn == LAST) && (w_next_cnt == r_trials)) begin
        r_state <= ST_LOST;
        r_over  <= 1'b1;
      end else begin
        r_turn <= (r_turn == LAST) ? '0 : r_turn + PW'(1);
      end
    end
  end

  always_comb begin
    remaining = '0;
    case (r_state)
      ST_PLAY, ST_LOST: remaining = r_trials - r_count[r_turn];
      ST_WON:           remaining = r_trials - r_count[r_winner];
      default:          remaining = '0;
    endcase
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
    assign count[g*CNT_W +: CNT_W] = r_count[g];
  end

  assign turn    = r_turn;
  assign state_o = r_state;
  assign over    = r_over;
  assign win     = r_win;
  assign winner  = r_winner;

endmodule

// File: tb/tb_trial_tracker.sv
// Directed, table-driven bench for trial_tracker (N=2, CNT_W=4), plus a
// rising-edge instance for the reset-with-button-held case.
module tb_trial_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       submit;
  logic       submit_r;
  logic       correct;
  logic [3:0] trials;

  logic [7:0] count,   count_r;
  logic [0:0] turn,    turn_r;
  logic [3:0] remaining, remaining_r;
  logic [1:0] state_o, state_r;
  logic       over,    over_r;
  logic       win,     win_r;
  logic [0:0] winner,  winner_r;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trial_tracker #(.N_PLAYERS(2), .CNT_W(4), .SUBMIT_EDGE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .submit(submit), .correct(correct),
    .trials(trials), .count(count), .turn(turn), .remaining(remaining),
    .state_o(state_o), .over(over), .win(win), .winner(winner)
  );

  trial_tracker #(.N_PLAYERS(2), .CNT_W(4), .SUBMIT_EDGE(1'b1)) u_dut_r (
    .clk(clk), .rst(rst), .start(start), .submit(submit_r), .correct(correct),
    .trials(trials), .count(count_r), .turn(turn_r), .remaining(remaining_r),
    .state_o(state_r), .over(over_r), .win(win_r), .winner(winner_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after the following posedge.
  task automatic step(input logic s_start, input logic s_sub, input logic s_cor,
                      input logic [3:0] s_tr);
    @(negedge clk);
    start   = s_start;
    submit  = s_sub;
    correct = s_cor;
    trials  = s_tr;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       submit;
    logic       correct;
    logic [3:0] trials;
    logic [1:0] e_state;
    logic [3:0] e_c0;
    logic [3:0] e_c1;
    logic       e_turn;
    logic [3:0] e_rem;
    logic       e_over;
    logic       e_win;
    logic       e_winner;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sb, input logic co, input logic [3:0] tr,
                              input logic [1:0] es, input logic [3:0] c0, input logic [3:0] c1,
                              input logic et, input logic [3:0] er, input logic eo,
                              input logic ew, input logic ewn);
    vec_t v;
    v.start = st; v.submit = sb; v.correct = co; v.trials = tr;
    v.e_state = es; v.e_c0 = c0; v.e_c1 = c1; v.e_turn = et; v.e_rem = er;
    v.e_over = eo; v.e_win = ew; v.e_winner = ewn;
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; submit = 1'b0; submit_r = 1'b1; correct = 1'b0; trials = 4'd0;

    // Reset state, rising-edge instance with its button held high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",  32'(state_o), 32'd0);
    check("rst_count",  32'(count),   32'd0);
    check("rst_over",   32'(over),    32'd0);
    check("rst_turn",   32'(turn),    32'd0);
    check("rst_rem",    32'(remaining), 32'd0);
    check("rstR_state", 32'(state_r), 32'd0);
    check("rstR_count", 32'(count_r), 32'd0);
    check("rstR_over",  32'(over_r),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0);

    // start with zero budget is ignored; budget 5 latches and survives a change.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("zero_start_state", 32'(state_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd5);
    check("start5_state", 32'(state_o), 32'd1);
    check("start5_rem",   32'(remaining), 32'd5);
    check("held_r_count", 32'(count_r), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd2);
    check("trials_chg_rem", 32'(remaining), 32'd5);
    step(1'b0, 1'b1, 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 4'd2);
    check("t5_ev_count", 32'(count), 32'h01);
    check("t5_ev_turn",  32'(turn),  32'd1);
    check("t5_ev_rem",   32'(remaining), 32'd5);
    check("held_r_count2", 32'(count_r), 32'd0);
    @(negedge clk); submit_r = 1'b0;
    @(negedge clk); submit_r = 1'b1;
    @(posedge clk); #1;
    check("rise_ev_count", 32'(count_r), 32'h01);
    check("rise_ev_turn",  32'(turn_r),  32'd1);

    // Table: LOST after 6 wrong guesses, WON on third guess, start vs event.
    //           st sb co tr    state c0 c1 turn rem over win wnr
    vecs.push_back(mk(1, 0, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 2, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 2, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 3, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 3, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd3, 3, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd3, 3, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd3, 3, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 2'd1, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 2'd2, 2, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd2, 2, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd2, 2, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 2'd1, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 2'd1, 1, 0, 1, 3, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].submit, vecs[i].correct, vecs[i].trials);
      check($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].e_state));
      check($sformatf("v%0d_count", i), 32'(count),   32'({vecs[i].e_c1, vecs[i].e_c0}));
      check($sformatf("v%0d_turn", i),  32'(turn),    32'(vecs[i].e_turn));
      check($sformatf("v%0d_rem", i),   32'(remaining), 32'(vecs[i].e_rem));
      check($sformatf("v%0d_over", i),  32'(over),    32'(vecs[i].e_over));
      check($sformatf("v%0d_win", i),   32'(win),     32'(vecs[i].e_win));
      if (vecs[i].e_win) check($sformatf("v%0d_winner", i), 32'(winner), 32'(vecs[i].e_winner));
    end

    // Asynchronous reset mid-round with count[0]=2 and the button held high.
    step(1'b1, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    check("pre_rst_count", 32'(count), 32'h12);
    step(1'b0, 1'b1, 1'b0, 4'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_count", 32'(count),   32'd0);
    check("async_rst_over",  32'(over),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_count", 32'(count),   32'd0);
    check("post_rst_rem",   32'(remaining), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
